// File: rtl/adder_pkg.sv
// Shared constants and the golden arithmetic model for the registered ripple adder.
// ref_add works at the maximum legal width; callers slice the low WIDTH+1 bits.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 64;

  function automatic logic [MAX_WIDTH:0] ref_add(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 c_in
  );
    return {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, c_in};
  endfunction

endpackage

// File: rtl/full_adder.sv
// One ripple-carry cell: sum and carry-out of a, b and the incoming carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_prop;

  assign w_prop = a ^ b;
  assign s      = w_prop ^ ci;
  assign co     = (a & b) | (ci & w_prop);

endmodule

// File: rtl/adder4.sv
// Registered WIDTH-bit ripple-carry adder: {c_out, sum} = a + b + c_in, one cycle latency.
// The reset clears the result register asynchronously; no internal pipelining.
module adder4
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             c_out,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH:0]   w_carry_p0;
  logic [WIDTH-1:0] w_sum_p0;
  logic [WIDTH-1:0] r_sum_p1;
  logic             r_c_out_p1;

  assign w_carry_p0[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_carry_p0[i]),
      .s  (w_sum_p0[i]),
      .co (w_carry_p0[i+1])
    );
  end

  // p0 -> p1: capture the settled carry chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_p1   <= '0;
      r_c_out_p1 <= 1'b0;
    end else begin
      r_sum_p1   <= w_sum_p0;
      r_c_out_p1 <= w_carry_p0[WIDTH];
    end
  end

  assign sum   = r_sum_p1;
  assign c_out = r_c_out_p1;

endmodule

// File: tb/tb_adder4.sv
// Directed self-checking bench for adder4 at WIDTH=4.
module tb_adder4;
  import adder_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic       c_out;
  logic [3:0] sum;

  int checks;
  int errors;

  adder4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .c_out (c_out),
    .sum   (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive operands away from the edge, clock once, sample 1 time unit after the edge.
  task automatic step(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                      input logic [4:0] exp, input string tag);
    a = ta; b = tb; c_in = tc;
    @(posedge clk);
    #1;
    check(tag, {c_out, sum}, exp);
  endtask

  function automatic logic [4:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                       input logic mc);
    logic [64:0] full;
    full = ref_add({60'd0, ma}, {60'd0, mb}, mc);
    return full[4:0];
  endfunction

  initial begin
    logic [3:0] ra, rb;
    logic       rc;
    checks = 0;
    errors = 0;
    rst = 1'b0; a = 4'hF; b = 4'hF; c_in = 1'b1;

    // Reset applied with no clock edge yet (first posedge at t=5)
    #1 rst = 1'b1;
    #1 check("reset_async", {c_out, sum}, 5'h00);
    @(posedge clk); @(posedge clk); #1;
    check("reset_hold", {c_out, sum}, 5'h00);
    @(negedge clk);
    rst = 1'b0;
    #1 check("reset_release_noedge", {c_out, sum}, 5'h00);
    @(posedge clk); #1;
    check("reset_release_edge", {c_out, sum}, 5'h1F);

    step(4'h0, 4'h0, 1'b0, 5'h00, "zero");
    step(4'hF, 4'h0, 1'b1, 5'h10, "propagate_F_0_1");
    step(4'h7, 4'h8, 1'b1, 5'h10, "propagate_7_8_1");
    step(4'h5, 4'h3, 1'b1, 5'h09, "mixed_5_3_1");
    step(4'h9, 4'h8, 1'b0, 5'h11, "mixed_9_8_0");
    step(4'hF, 4'hF, 1'b1, 5'h1F, "max_F_F_1");

    // Outputs hold between edges even when inputs change
    a = 4'h1; b = 4'h1; c_in = 1'b0;
    #2 check("hold_between_edges", {c_out, sum}, 5'h1F);
    @(posedge clk); #1;
    check("after_hold", {c_out, sum}, 5'h02);

    for (int i = 0; i < 5; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      step(ra, rb, rc, model(ra, rb, rc), $sformatf("b2b_%0d", i));
    end

    // Mid-stream reset pulse between edges
    step(4'hA, 4'h3, 1'b0, 5'h0D, "pre_midreset");
    #2 rst = 1'b1;
    #1 check("midreset_async", {c_out, sum}, 5'h00);
    #1 rst = 1'b0;
    #1 check("midreset_released_noedge", {c_out, sum}, 5'h00);
    @(posedge clk); #1;
    check("midreset_recover", {c_out, sum}, 5'h0D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder4.md
Name: adder4

Overview:
- Registered WIDTH-bit binary adder with carry-in and carry-out; default WIDTH=4.
- Computes {c_out, sum} = a + b + c_in. Result is captured in an output register on each rising clock edge.
- Leaf arithmetic block for datapaths that need a registered sum with an explicit carry chain.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..64.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous, active-high reset.
- a, input, WIDTH, operand A, unsigned.
- b, input, WIDTH, operand B, unsigned.
- c_in, input, 1, carry-in, weight 1.
- c_out, output, 1, registered carry-out (bit WIDTH of the full result).
- sum, output, WIDTH, registered low WIDTH bits of the result.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Arithmetic: the full result is WIDTH+1 bits wide and equals a + b + c_in, all unsigned. No saturation; the result wraps modulo 2^(WIDTH+1) by construction.
- Carry chain: ripple-carry through WIDTH full-adder cells.
  - Cell i computes s[i] = a[i] ^ b[i] ^ c[i] and c[i+1] = (a[i]&b[i]) | (c[i]&(a[i]^b[i])).
  - c[0] = c_in; c_out takes c[WIDTH].
- Latency: exactly 1 cycle. Inputs present before rising edge N appear on sum/c_out after edge N.
  - Outputs hold their value between edges and change only on a clock edge or on reset.
- Throughput: a new operand set every cycle. No handshake or valid signals; every cycle is a valid computation.
- Reset:
  - rst=1 forces sum=0 and c_out=0 immediately, with no clock required.
  - Outputs stay at 0 for as long as rst is high, regardless of the inputs.
- Reset release: the first rising edge with rst=0 captures the current inputs.
- Reset asserted mid-stream: any in-flight result is discarded; there is no recovery of the lost value.
- Boundaries:
  - All-ones + all-ones + 1 gives sum = all-ones, c_out=1.
  - All-ones + 0 + 1 gives sum=0, c_out=1 (full carry propagation across every bit).
- Inputs containing X/Z are not supported; propagation of X is acceptable.
- The combinational path a/b/c_in -> register D must meet timing at WIDTH=4 in the default flow. At larger widths, timing is the integrator's responsibility; no internal pipelining is provided.

Decomposition:
- Package adder_pkg:
  - localparam DEFAULT_WIDTH = 4.
  - Function ref_add(a, b, c_in), returning the WIDTH+1-bit golden result for scoreboards.
- Sub-module full_adder: 1-bit inputs a, b, ci; 1-bit outputs s, co; purely combinational.
- adder4 instantiates WIDTH full_adder cells in a generate loop, plus the output register block.

Test Plan:
- Reset: hold rst=1 with a=F, b=F, c_in=1 -> sum=0, c_out=0 while reset is high, with no clock edge needed. Release rst, then one edge -> sum=F, c_out=1.
- Zero: a=0, b=0, c_in=0 -> after 1 edge sum=0x0, c_out=0.
- Full propagate: a=F, b=0, c_in=1 -> sum=0x0, c_out=1. Also a=7, b=8, c_in=1 -> sum=0x0, c_out=1.
- Mixed: a=5, b=3, c_in=1 -> sum=0x9, c_out=0. Then a=9, b=8, c_in=0 -> sum=0x1, c_out=1.
- Back-to-back: change operands every cycle for 5 random vectors -> each output matches ref_add of the previous cycle's inputs, with exactly 1-cycle latency.
- Mid-stream reset: pulse rst between clock edges while a=A, b=3 -> outputs drop to 0 asynchronously. The next edge after release shows sum=0xD, c_out=0.
